bcd2ascii_tx: RTL and testbench
===============================

BCD2ASCII_TX -- requirements
Module: bcd2ascii_tx

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 2, the number of input record buffer entries (power of two, at least 2).
REQ-002 SHALL provide parameter TERM_EN, default 1; when set to 1, each record is terminated with CR LF (0x0D 0x0A).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port bcd_vld, input, 1 bit: a BCD record is present on bcd this cycle; there is no backpressure to the source.
REQ-006 SHALL have port bcd, input, 17 bits: [16] sign, [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-007 SHALL have port ascii_data, output, 8 bits: the current ASCII byte.
REQ-008 SHALL have port ascii_vld, output, 1 bit: ascii_data is valid.
REQ-009 SHALL have port ascii_rdy, input, 1 bit: the sink accepts the byte; a transfer occurs when ascii_vld and ascii_rdy are both high.
REQ-010 SHALL have port busy, output, 1 bit: high when the FIFO is non-empty or the FSM is not in IDLE.
REQ-011 SHALL have port ovf, output, 1 bit: sticky flag indicating a record was dropped.
REQ-012 SHALL have port ovf_clr, input, 1 bit: clears ovf.

Function
REQ-013 SHALL push {bcd} into the FIFO at an edge where bcd_vld=1 and the FIFO is not full.
REQ-014 SHALL drop the record when bcd_vld=1 and the FIFO is full, even if a pop occurs at the same edge, and SHALL set ovf.
REQ-015 SHALL give ovf set priority over ovf_clr when both occur at the same edge.
REQ-016 SHALL implement FSM states IDLE, SIGN, DIGIT, CR, LF.
REQ-017 IDLE: when the FIFO is non-empty, SHALL pop one record into a holding register; next state is SIGN if sign=1 and magnitude is non-zero, otherwise DIGIT.
REQ-018 SHALL select the first digit to emit as the most significant non-zero digit among thousands, hundreds and tens; units are always emitted (leading-zero suppression).
REQ-019 SHALL suppress the sign for negative zero: 17'h10000 produces "0" only.
REQ-020 SHALL encode a digit of 0-9 as 0x30+digit; SHALL encode a digit of 10-15 as 0x3F ('?'); a non-zero invalid digit counts as non-zero for suppression.
REQ-021 SIGN: SHALL present 0x2D and advance to DIGIT on transfer.
REQ-022 DIGIT: SHALL present the current digit; on transfer, SHALL move to the next lower digit, or after units go to CR (TERM_EN=1) or IDLE (TERM_EN=0).
REQ-023 CR: SHALL present 0x0D and go to LF on transfer.
REQ-024 LF: SHALL present 0x0A and go to IDLE on transfer.
REQ-025 SHALL drive ascii_vld and ascii_data from registers; ascii_vld=1 exactly in SIGN, DIGIT, CR and LF.
REQ-026 SHALL hold ascii_data stable while ascii_vld=1 and ascii_rdy=0.
REQ-027 SHALL not deassert ascii_vld until a transfer occurs.
REQ-028 Latency: with the FIFO empty, the FSM in IDLE and bcd_vld high in cycle N, the first ascii_vld SHALL be high in cycle N+2.
REQ-029 With ascii_rdy held at 1, bytes within a record SHALL be emitted on consecutive cycles.
REQ-030 SHALL spend exactly one IDLE cycle between records.
REQ-031 SHALL allow a push and a pop at the same edge when the FIFO is not full; the FIFO occupancy then stays unchanged.
REQ-032 SHALL let FIFO pointers wrap modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer bit.

Reset
REQ-033 On an rst=1 edge, SHALL set: FIFO empty, state IDLE, ascii_vld=0, ascii_data=8'h00, ovf=0, busy=0, and holding register 0.
REQ-034 Reset mid-record SHALL abort the record without completing it; buffered records SHALL be discarded.
REQ-035 bcd_vld SHALL be ignored in any cycle where rst=1.

Verification
REQ-036 bcd=17'h11024, ascii_rdy=1 -> bytes 2D 31 30 32 34 0D 0A on consecutive cycles; first ascii_vld at N+2.
REQ-037 bcd=17'h00007 -> 37 0D 0A; bcd=17'h10000 -> 30 0D 0A; bcd=17'h000A0 -> 3F 30 0D 0A.
REQ-038 bcd=17'h00512 with ascii_rdy alternating 0/1 -> 35 31 32 0D 0A; ascii_data unchanged during every stall cycle.
REQ-039 FIFO_DEPTH=2, ascii_rdy=0, four back-to-back bcd_vld (A,B,C,D) -> A popped at edge N+1, B and C buffered, D dropped, ovf=1; after ascii_rdy=1, records A, B, C output in order; ovf_clr together with a new drop leaves ovf=1.
REQ-040 rst=1 after 2 bytes of 17'h11024 transferred -> ascii_vld=0 and busy=0 the next cycle; a following 17'h00003 yields 33 0D 0A.
REQ-041 TERM_EN=0, bcd=17'h00999 -> 39 39 39 only; the next record starts after one IDLE cycle.

Source files
------------

// File: rtl/bcd2ascii_tx.sv
// bcd2ascii_tx
//   Buffers signed 4-digit BCD records and serialises each one as ASCII text.
//   Leading zeros are suppressed, negative zero prints without a sign, and a
//   digit value of 10-15 prints as '?'. Optionally each record ends in CR LF.
//
// Parameters
//   FIFO_DEPTH : input record buffer entries (power of two, >= 2)
//   TERM_EN    : 1 = append CR LF (0x0D 0x0A) after every record
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bcd_vld    : record present on bcd this cycle (no backpressure)
//   bcd[16:0]  : [16] sign, [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units
//   ascii_data : current output byte (registered)
//   ascii_vld  : ascii_data valid (registered)
//   ascii_rdy  : sink accepts the byte
//   busy       : buffer non-empty or serialiser active
//   ovf        : sticky, set when a record arrives while the buffer is full
//   ovf_clr    : clears ovf (a simultaneous drop wins)
//
// Output handshake: a byte moves when ascii_vld and ascii_rdy are both high at
// a rising edge. Once ascii_vld is raised, ascii_vld and ascii_data hold their
// values until that transfer happens.

module bcd2ascii_tx #(
    parameter int FIFO_DEPTH = 2,
    parameter bit TERM_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bcd_vld,
    input  logic [16:0] bcd,
    output logic [7:0]  ascii_data,
    output logic        ascii_vld,
    input  logic        ascii_rdy,
    output logic        busy,
    output logic        ovf,
    input  logic        ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SIGN  = 3'd1,
        DIGIT = 3'd2,
        CR    = 3'd3,
        LF    = 3'd4
    } state_t;

    // Record buffer; the extra pointer bit tells full from empty.
    logic [16:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        drop;
    logic        pop;
    logic [16:0] head;

    state_t      state;
    state_t      state_n;
    logic [16:0] hold;
    logic [16:0] hold_n;
    logic [1:0]  idx;      // digit being shown: 3 thousands .. 0 units
    logic [1:0]  idx_n;
    logic [1:0]  first_idx;
    logic [7:0]  data_n;
    logic        xfer;

    function automatic logic [7:0] enc(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    function automatic logic [3:0] pick(input logic [16:0] r, input logic [1:0] i);
        logic [3:0] d;
        case (i)
            2'd3:    d = r[15:12];
            2'd2:    d = r[11:8];
            2'd1:    d = r[7:4];
            default: d = r[3:0];
        endcase
        return d;
    endfunction

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Fullness is judged before any pop at the same edge, so a full buffer
    // drops the incoming record even while the serialiser is taking one out.
    assign push  = bcd_vld && !full;
    assign drop  = bcd_vld && full;
    assign head  = mem[rd_ptr[AW-1:0]];
    assign xfer  = ascii_vld && ascii_rdy;
    assign busy  = !empty || (state != IDLE);

    // Most significant non-zero digit among thousands/hundreds/tens; units
    // always print. An invalid digit (10-15) counts as non-zero.
    always_comb begin
        first_idx = 2'd0;
        if (head[15:12] != 4'd0)     first_idx = 2'd3;
        else if (head[11:8] != 4'd0) first_idx = 2'd2;
        else if (head[7:4] != 4'd0)  first_idx = 2'd1;
    end

    always_comb begin
        state_n = state;
        hold_n  = hold;
        idx_n   = idx;
        data_n  = ascii_data;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    hold_n = head;
                    idx_n  = first_idx;
                    // Negative zero prints as "0" with no sign.
                    if (head[16] && (head[15:0] != 16'h0000)) begin
                        state_n = SIGN;
                        data_n  = 8'h2D;
                    end else begin
                        state_n = DIGIT;
                        data_n  = enc(pick(head, first_idx));
                    end
                end
            end
            SIGN: begin
                if (xfer) begin
                    state_n = DIGIT;
                    data_n  = enc(pick(hold, idx));
                end
            end
            DIGIT: begin
                if (xfer) begin
                    if (idx == 2'd0) begin
                        if (TERM_EN) begin
                            state_n = CR;
                            data_n  = 8'h0D;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        idx_n  = idx - 2'd1;
                        data_n = enc(pick(hold, idx - 2'd1));
                    end
                end
            end
            CR: begin
                if (xfer) begin
                    state_n = LF;
                    data_n  = 8'h0A;
                end
            end
            LF: begin
                if (xfer) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            state      <= IDLE;
            hold       <= 17'h0;
            idx        <= 2'd0;
            ascii_vld  <= 1'b0;
            ascii_data <= 8'h00;
            ovf        <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= bcd;
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            state      <= state_n;
            hold       <= hold_n;
            idx        <= idx_n;
            ascii_vld  <= (state_n != IDLE);
            ascii_data <= data_n;
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd2ascii_tx.sv
module tb_bcd2ascii_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bcd_vld = 1'b0;
  logic [16:0] bcd = 17'h0;
  logic [7:0]  ascii_data;
  logic        ascii_vld;
  logic        ascii_rdy;
  logic        busy;
  logic        ovf;
  logic        ovf_clr = 1'b0;

  // second instance without CR LF termination
  logic        bcd_vld1 = 1'b0;
  logic [16:0] bcd1 = 17'h0;
  logic [7:0]  ascii_data1;
  logic        ascii_vld1;
  logic        ascii_rdy1 = 1'b1;
  logic        busy1;
  logic        ovf1;
  logic        ovf_clr1 = 1'b0;

  int n_checks = 0;
  int n_bad = 0;
  int xfer_cnt = 0;
  int rdy_mode = 0;   // 0 always ready, 1 alternate, 2 random, 3 never
  logic [7:0] exp_q[$];
  logic       stalled = 1'b0;
  logic [7:0] stall_data = 8'h00;

  bcd2ascii_tx #(.FIFO_DEPTH(2), .TERM_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bcd_vld(bcd_vld), .bcd(bcd),
    .ascii_data(ascii_data), .ascii_vld(ascii_vld), .ascii_rdy(ascii_rdy),
    .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  bcd2ascii_tx #(.FIFO_DEPTH(2), .TERM_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bcd_vld(bcd_vld1), .bcd(bcd1),
    .ascii_data(ascii_data1), .ascii_vld(ascii_vld1), .ascii_rdy(ascii_rdy1),
    .busy(busy1), .ovf(ovf1), .ovf_clr(ovf_clr1)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check task ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // Text a record should print: optional '-', digits from the first
  // non-zero one down to units, then CR LF.
  function automatic void model(input logic [16:0] r);
    int d[4];
    int start;
    bit nz;
    d[3] = int'(r[15:12]);
    d[2] = int'(r[11:8]);
    d[1] = int'(r[7:4]);
    d[0] = int'(r[3:0]);
    nz = (d[0] + d[1] + d[2] + d[3]) != 0;
    start = 3;
    while (start > 0 && d[start] == 0) start--;
    if (r[16] && nz) exp_q.push_back(8'h2D);
    for (int i = start; i >= 0; i--)
      exp_q.push_back(d[i] < 10 ? 8'(48 + d[i]) : 8'h3F);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // ---------------- sink ready driver ----------------
  initial begin
    ascii_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: ascii_rdy = 1'b1;
        1: ascii_rdy = ~ascii_rdy;
        2: ascii_rdy = 1'($urandom_range(0, 1));
        default: ascii_rdy = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_vld", ascii_vld, 1);
        check("stall_data", ascii_data, stall_data);
      end
      if (ascii_vld && ascii_rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", exp_q.size(), 1);
        end else begin
          check("byte", ascii_data, exp_q.pop_front());
        end
        xfer_cnt++;
      end
      stalled = ascii_vld && !ascii_rdy;
      stall_data = ascii_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [16:0] r);
    tick();
    bcd_vld = 1'b1;
    bcd = r;
    model(r);
  endtask

  task automatic send_dropped(input logic [16:0] r);
    tick();
    bcd_vld = 1'b1;
    bcd = r;
  endtask

  task automatic idle();
    tick();
    bcd_vld = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_drain"}, exp_q.size() == 0, 1);
    exp_q.delete();
    @(negedge clk);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_vld"}, ascii_vld, 0);
  endtask

  task automatic pulse_clr();
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int n;
    logic [16:0] r;

    // reset, with bcd_vld asserted that must be ignored
    rst = 1'b1;
    bcd_vld = 1'b1;
    bcd = 17'h00123;
    bcd_vld1 = 1'b1;
    bcd1 = 17'h00456;
    repeat (3) tick();
    @(negedge clk);
    check("rst_vld", ascii_vld, 0);
    check("rst_data", ascii_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_vld1", ascii_vld1, 0);
    check("rst_busy1", busy1, 0);
    tick();
    rst = 1'b0;
    bcd_vld = 1'b0;
    bcd_vld1 = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    @(negedge clk);
    check("post_rst_vld", ascii_vld, 0);
    check("post_rst_busy1", busy1, 0);

    // -1024: latency N+2 then seven bytes back to back
    rdy_mode = 0;
    send(17'h11024);            // cycle N
    @(negedge clk);
    check("lat_n", ascii_vld, 0);
    idle();                     // cycle N+1
    @(negedge clk);
    check("lat_n1", ascii_vld, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("consec_vld", ascii_vld, 1);
    end
    @(negedge clk);
    check("gap_idle", ascii_vld, 0);
    wait_drain("m1024", 50);

    // small, negative zero, invalid digit
    send(17'h00007); idle(); wait_drain("r7", 50);
    send(17'h10000); idle(); wait_drain("negzero", 50);
    send(17'h000A0); idle(); wait_drain("inval", 50);

    // stalls with alternating ready
    rdy_mode = 1;
    send(17'h00512); idle(); wait_drain("stall512", 100);
    rdy_mode = 0;

    // overflow: A popped, B and C buffered, D dropped
    rdy_mode = 3;
    send(17'h00001);
    send(17'h00022);
    send(17'h10333);
    send_dropped(17'h04444);
    idle();
    @(negedge clk);
    check("ovf_set", ovf, 1);
    check("ovf_busy", busy, 1);
    rdy_mode = 0;
    wait_drain("ovf_abc", 100);
    pulse_clr();
    @(negedge clk);
    check("ovf_clr", ovf, 0);

    // drop in the same cycle as ovf_clr: set wins
    rdy_mode = 3;
    send(17'h00005);
    send(17'h00060);
    send(17'h00700);
    tick();
    bcd_vld = 1'b1;
    bcd = 17'h08000;
    ovf_clr = 1'b1;
    tick();
    bcd_vld = 1'b0;
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_set_prio", ovf, 1);
    pulse_clr();
    @(negedge clk);
    check("ovf_clr2", ovf, 0);
    rdy_mode = 0;
    wait_drain("ovf_xyz", 100);

    // reset after two bytes of -1024
    rdy_mode = 0;
    send(17'h11024);
    idle();
    base = xfer_cnt;
    n = 0;
    while (xfer_cnt < base + 2 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("mid_rst_reach", xfer_cnt >= base + 2, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_vld", ascii_vld, 0);
    check("mid_rst_busy", busy, 0);
    send(17'h00003); idle(); wait_drain("after_rst", 50);

    // no termination: 999 then 42 queued behind it
    tick();
    bcd_vld1 = 1'b1;
    bcd1 = 17'h00999;          // cycle N
    tick();
    bcd1 = 17'h00042;          // cycle N+1
    tick();
    bcd_vld1 = 1'b0;           // cycle N+2
    @(negedge clk);
    check("nt_b0_vld", ascii_vld1, 1);
    check("nt_b0", ascii_data1, 8'h39);
    @(negedge clk);
    check("nt_b1", ascii_data1, 8'h39);
    @(negedge clk);
    check("nt_b2_vld", ascii_vld1, 1);
    check("nt_b2", ascii_data1, 8'h39);
    @(negedge clk);
    check("nt_idle", ascii_vld1, 0);
    @(negedge clk);
    check("nt_c0_vld", ascii_vld1, 1);
    check("nt_c0", ascii_data1, 8'h34);
    @(negedge clk);
    check("nt_c1", ascii_data1, 8'h32);
    @(negedge clk);
    check("nt_end", ascii_vld1, 0);
    check("nt_busy", busy1, 0);

    // randomized records
    for (int k = 0; k < 40; k++) begin
      rdy_mode = $urandom_range(0, 2);
      for (int j = 0; j <= int'($urandom_range(0, 1)); j++) begin
        case ($urandom_range(0, 3))
          0: r = 17'($urandom);
          1: begin
            r = {1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            r[15:0] = r[15:0] >> (4 * $urandom_range(0, 3));
          end
          2: r = {1'($urandom_range(0, 1)), 16'h0000};
          default: begin
            r = {1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            r[4 * $urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
          end
        endcase
        send(r);
      end
      idle();
      wait_drain("rand", 600);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
